// File: rtl/wb_pkg.sv
// Shared types and default sizing for the multi-lane write-back stage.
package wb_pkg;

  localparam int WB_LANES  = 2;
  localparam int WB_WPORTS = 1;
  localparam int WB_DEPTH  = 4;
  localparam int WB_DW     = 32;
  localparam int WB_RW     = 5;

  typedef enum logic [2:0] {
    LW  = 3'd0,
    LB  = 3'd1,
    LBU = 3'd2,
    LH  = 3'd3,
    LHU = 3'd4
  } load_t;

  typedef struct packed {
    logic [WB_RW-1:0] idx;
    logic [WB_DW-1:0] data;
  } wb_entry_t;

endpackage

// File: rtl/writeback_lanes_load_extend.sv
// Per-lane result selection: ALU result or load data with sub-word
// extraction and sign/zero extension. Purely combinational.
module load_extend
  import wb_pkg::*;
#(
  parameter int DW = WB_DW
) (
  input  logic          memto_reg,
  input  load_t         load_type,
  input  logic [1:0]    byte_off,
  input  logic [DW-1:0] read_data,
  input  logic [DW-1:0] alu_out,
  output logic [DW-1:0] result
);

  function automatic logic [DW-1:0] ext_byte(input logic [7:0] b, input logic sgn);
    return {{(DW-8){sgn & b[7]}}, b};
  endfunction

  function automatic logic [DW-1:0] ext_half(input logic [15:0] h, input logic sgn);
    return {{(DW-16){sgn & h[15]}}, h};
  endfunction

  logic [7:0]  sel_byte;
  logic [15:0] sel_half;

  // Halfword selection uses only the upper offset bit; the low bit is ignored.
  assign sel_byte = read_data[8*byte_off +: 8];
  assign sel_half = read_data[16*byte_off[1] +: 16];

  // Result mux: ALU path unless this lane retires a load.
  always_comb begin
    result = alu_out;
    if (memto_reg) begin
      unique case (load_type)
        LW:      result = read_data;
        LB:      result = ext_byte(sel_byte, 1'b1);
        LBU:     result = ext_byte(sel_byte, 1'b0);
        LH:      result = ext_half(sel_half, 1'b1);
        LHU:     result = ext_half(sel_half, 1'b0);
        default: result = read_data;
      endcase
    end
  end

endmodule

// File: rtl/writeback_lanes.sv
// Multi-lane write-back: per-lane result formation, compacted in-order
// write queue, and drain onto WPORTS register-file write ports with
// same-destination masking among ports popped together.
module writeback_lanes
  import wb_pkg::*;
#(
  parameter int LANES  = WB_LANES,
  parameter int WPORTS = WB_WPORTS,
  parameter int DEPTH  = WB_DEPTH,
  parameter int DW     = WB_DW,
  parameter int RW     = WB_RW
) (
  input  logic                          clk,
  input  logic                          resetn,
  input  logic [LANES-1:0]              ValidWIn,
  input  logic [LANES-1:0]              RegWriteWIn,
  input  logic [LANES-1:0]              MemtoRegWIn,
  input  logic [LANES-1:0][2:0]         LoadTypeWIn,
  input  logic [LANES-1:0][1:0]         ByteOffWIn,
  input  logic [LANES-1:0][DW-1:0]      ReadDataWIn,
  input  logic [LANES-1:0][DW-1:0]      ALUOutWIn,
  input  logic [LANES-1:0][RW-1:0]      WriteRegWIn,
  output logic                          ReadyWOut,
  output logic [WPORTS-1:0]             RegWriteWOut,
  output logic [WPORTS-1:0][RW-1:0]     WriteRegWOut,
  output logic [WPORTS-1:0][DW-1:0]     ResultWOut,
  output logic [$clog2(DEPTH+1)-1:0]    OccupancyWOut
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [AW-1:0] head, tail;
  logic [CW-1:0] count;
  logic [RW-1:0] q_idx  [DEPTH];
  logic [DW-1:0] q_data [DEPTH];

  logic [DW-1:0]    lane_res [LANES];
  logic [LANES-1:0] qual;
  logic [LANES-1:0] wr_en;
  logic [AW-1:0]    wr_addr [LANES];
  logic [CW-1:0]    enq_n;
  logic [CW-1:0]    deq_n;
  logic             accept;

  logic [AW-1:0]                rd_addr [WPORTS];
  logic [WPORTS-1:0]            pop_en;
  logic [WPORTS-1:0]            en_next;
  logic [WPORTS-1:0][RW-1:0]    idx_next;
  logic [WPORTS-1:0][DW-1:0]    data_next;

  // Stage boundary: Memory pipeline register -> lane result formation.
  for (genvar l = 0; l < LANES; l++) begin : g_lane
    load_extend #(.DW(DW)) u_ext (
      .memto_reg (MemtoRegWIn[l]),
      .load_type (load_t'(LoadTypeWIn[l])),
      .byte_off  (ByteOffWIn[l]),
      .read_data (ReadDataWIn[l]),
      .alu_out   (ALUOutWIn[l]),
      .result    (lane_res[l])
    );
    assign qual[l] = ValidWIn[l] & RegWriteWIn[l] & (WriteRegWIn[l] != '0);
  end

  // Ready looks only at registered occupancy, so a same-edge pop never helps.
  assign ReadyWOut     = (DEPTH - int'(count)) >= LANES;
  assign accept        = ReadyWOut;
  assign OccupancyWOut = count;

  // Compact qualifying lanes into consecutive slots starting at tail.
  always_comb begin
    enq_n = '0;
    for (int l = 0; l < LANES; l++) begin
      wr_en[l]   = accept & qual[l];
      wr_addr[l] = tail + AW'(enq_n);
      if (wr_en[l]) enq_n = enq_n + CW'(1);
    end
  end

  // Pop up to WPORTS oldest entries; an older port loses to a younger one
  // aimed at the same register so the last value in program order wins.
  always_comb begin
    deq_n     = (count < CW'(WPORTS)) ? count : CW'(WPORTS);
    en_next   = '0;
    idx_next  = '0;
    data_next = '0;
    for (int p = 0; p < WPORTS; p++) begin
      rd_addr[p] = head + AW'(p);
      pop_en[p]  = CW'(p) < deq_n;
      if (pop_en[p]) begin
        en_next[p]   = 1'b1;
        idx_next[p]  = q_idx[rd_addr[p]];
        data_next[p] = q_data[rd_addr[p]];
      end
    end
    for (int p = 0; p < WPORTS; p++) begin
      for (int q = p + 1; q < WPORTS; q++) begin
        if (pop_en[p] && pop_en[q] && (q_idx[rd_addr[q]] == q_idx[rd_addr[p]]))
          en_next[p] = 1'b0;
      end
    end
  end

  // Queue storage: data only, no reset needed since count gates every read.
  always_ff @(posedge clk) begin
    for (int l = 0; l < LANES; l++) begin
      if (wr_en[l]) begin
        q_idx[wr_addr[l]]  <= WriteRegWIn[l];
        q_data[wr_addr[l]] <= lane_res[l];
      end
    end
  end

  // Stage boundary: queue head -> register-file write ports.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      head         <= '0;
      tail         <= '0;
      count        <= '0;
      RegWriteWOut <= '0;
      WriteRegWOut <= '0;
      ResultWOut   <= '0;
    end else begin
      head         <= head + AW'(deq_n);
      tail         <= tail + AW'(enq_n);
      count        <= count + enq_n - deq_n;
      RegWriteWOut <= en_next;
      WriteRegWOut <= idx_next;
      ResultWOut   <= data_next;
    end
  end

endmodule
